// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks.
// Contents:
//   SEG_0 .. SEG_9, SEG_DASH, SEG_OFF : active-low segment patterns {a,b,c,d,e,f,g}, a at bit 6
//   digit_idx_t                       : 2-bit index of the digit currently being scanned
//   scan_state_e                      : scan FSM states
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } scan_state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
// Codes above 9 show a dash (segment g only).
// Ports:
//   bcd_i  [3:0] : BCD digit
//   seg_o  [6:0] : segments {a,b,c,d,e,f,g}, active-low
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed 7-segment display driver.
// Latches four BCD digits plus decimal points and scans them onto a shared
// segment bus with per-slot blanking at the end of every digit slot.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros
// (digit 0 is never suppressed).
// Ports:
//   C50    : clock, rising edge
//   Rst    : synchronous reset, active-high
//   Load   : latch strobe for Digits/DpIn
//   Digits : four BCD digits, [3:0] = digit 0 (rightmost)
//   DpIn   : decimal point per digit, 1 = lit
//   An     : anodes, active-low, An[i] = digit i (registered)
//   Seg    : segments {a..g}, active-low, a at bit 6 (registered)
//   Dp     : decimal point, active-low (registered)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_SHOW  | digit idx lit, from slot start until SLOT-BLANK_CYC-1
// ST_BLANK | all anodes off for the last BLANK_CYC cycles of the slot
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 500
) (
    input  logic        C50,
    input  logic        Rst,
    input  logic        Load,
    input  logic [15:0] Digits,
    input  logic [3:0]  DpIn,
    output logic [3:0]  An,
    output logic [6:0]  Seg,
    output logic        Dp
);

    localparam int SLOT = CLK_HZ / SCAN_HZ;
    localparam int CW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] SHOW_END = CW'(SLOT - BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_END = CW'(SLOT - 1);

    scan_state_e   state_q, state_d;
    digit_idx_t    idx_q, idx_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [15:0]   dig_q, dig_d;
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpo_q, dpo_d;

    logic [3:0]    cur_bcd;
    logic [6:0]    cur_seg;
    logic          lz_blank;

    assign cur_bcd = dig_q[{idx_q, 2'b00} +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    // A digit is a leading zero when it and every digit above it are zero.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank = 1'b0;
        case (idx_q)
            2'd1:    lz_blank = (dig_q[15:4]  == 12'h000);
            2'd2:    lz_blank = (dig_q[15:8]  == 8'h00);
            2'd3:    lz_blank = (dig_q[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_cnt_d = (slot_cnt_q == SLOT_END) ? '0 : slot_cnt_q + CW'(1);
        dig_d      = Load ? Digits : dig_q;
        dp_d       = Load ? DpIn   : dp_q;
        an_d       = 4'b1111;
        seg_d      = SEG_OFF;
        dpo_d      = 1'b1;

        case (state_q)
            ST_SHOW: begin
                if (slot_cnt_q == SHOW_END) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (slot_cnt_q == SLOT_END) begin
                    state_d = ST_SHOW;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = ST_SHOW;
        endcase

        // Outputs are decoded from the current registers, so they trail
        // any state/index/data change by exactly one cycle.
        if (state_q == ST_SHOW) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? SEG_OFF : cur_seg;
            dpo_d = ~dp_q[idx_q];
        end
    end

    always_ff @(posedge C50) begin
        if (Rst) begin
            state_q    <= ST_SHOW;
            idx_q      <= '0;
            slot_cnt_q <= '0;
            dig_q      <= '0;
            dp_q       <= '0;
            an_q       <= 4'b1111;
            seg_q      <= SEG_OFF;
            dpo_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
            dig_q      <= dig_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dpo_q      <= dpo_d;
        end
    end

    assign An  = an_q;
    assign Seg = seg_q;
    assign Dp  = dpo_q;

endmodule
